// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 device-to-host frame receiver that strips E0/F0 prefixes
// and presents make codes as a held byte with a one-cycle valid strobe.
module ps2_scan_receiver #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyboardValue,
   output logic       keyValid,
   output logic       keyExtended,
   output logic       parityError,
   output logic       frameError
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state;
   logic clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_d, par, ext, brk, fall;
   logic [FW-1:0] fcnt;
   logic [TW-1:0] tcnt;
   logic [2:0] bcnt;
   logic [7:0] sh;
   assign fall = filt_d & ~filt;
   // Bus idles high, so every conditioning flop resets to 1 to avoid a false edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         {clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_d} <= '1;
         fcnt <= '0;
      end else begin
         {clk_s2, clk_s1} <= {clk_s1, ps2_clk};
         {dat_s2, dat_s1} <= {dat_s1, ps2_data};
         filt_d <= filt;
         if (clk_s2 == filt) fcnt <= '0;
         else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= clk_s2;
            fcnt <= '0;
         end else fcnt <= fcnt + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         tcnt <= '0;
         bcnt <= '0;
         sh <= '0;
         par <= 1'b0;
         ext <= 1'b0;
         brk <= 1'b0;
         keyboardValue <= 8'h00;
         keyExtended <= 1'b0;
         keyValid <= 1'b0;
         parityError <= 1'b0;
         frameError <= 1'b0;
      end else begin
         keyValid <= 1'b0;
         parityError <= 1'b0;
         frameError <= 1'b0;
         tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
         if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            frameError <= 1'b1;
            ext <= 1'b0;
            brk <= 1'b0;
            tcnt <= '0;
         end else if (fall) begin
            case (state)
               IDLE:
                  if (dat_s2) begin
                     frameError <= 1'b1;
                     ext <= 1'b0;
                     brk <= 1'b0;
                  end else begin
                     state <= DATA;
                     bcnt <= '0;
                  end
               DATA: begin
                  sh <= {dat_s2, sh[7:1]};
                  bcnt <= bcnt + 1'b1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par <= dat_s2;
                  state <= STOP;
               end
               default: begin
                  state <= IDLE;
                  if (!dat_s2 || !(^{sh, par})) begin
                     frameError <= ~dat_s2;
                     parityError <= dat_s2;
                     ext <= 1'b0;
                     brk <= 1'b0;
                  end else if (sh == 8'hE0) ext <= 1'b1;
                  else if (sh == 8'hF0) brk <= 1'b1;
                  else begin
                     if (!brk) begin
                        keyboardValue <= sh;
                        keyExtended <= ext;
                        keyValid <= 1'b1;
                     end
                     ext <= 1'b0;
                     brk <= 1'b0;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: scoreboard bench; stimulus pushes expected pulses, a monitor pops and checks them.
module tb_ps2_scan_receiver;
   localparam int TO = 2000;
   typedef struct {int kind; logic [7:0] val; logic ext;} item_t;
   logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1;
   logic [7:0] keyboardValue;
   logic keyValid, keyExtended, parityError, frameError;
   item_t q[$];
   int total = 0, bad = 0;
   logic [7:0] exp_kv = 8'h00;

   ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keyboardValue(keyboardValue), .keyValid(keyValid), .keyExtended(keyExtended),
      .parityError(parityError), .frameError(frameError));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d, input logic flip);
      return {1'b1, (~^d) ^ flip, d, 1'b0};
   endfunction

   task automatic bit_out(input logic b);
      ps2_data = b;
      repeat (5) @(posedge clk);
      ps2_clk = 0;
      repeat (10) @(posedge clk);
      ps2_clk = 1;
      repeat (5) @(posedge clk);
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) bit_out(f[i]);
      ps2_data = 1;
   endtask

   task automatic send(input logic [7:0] d, input logic flip);
      send_bits(frame(d, flip), 11);
      repeat (30) @(posedge clk);
   endtask

   task automatic expect_key(input logic [7:0] v, input logic e);
      q.push_back('{0, v, e});
      exp_kv = v;
   endtask

   task automatic expect_err(input int kind);
      q.push_back('{kind, exp_kv, 1'b0});
   endtask

   always @(negedge clk) begin
      if (!rst && (keyValid || parityError || frameError)) begin
         item_t it;
         chk("one_hot_pulse", 32'($countones({keyValid, parityError, frameError})), 32'd1);
         if (q.size() == 0) chk("unexpected_pulse", {29'd0, keyValid, parityError, frameError}, 32'd0);
         else begin
            it = q.pop_front();
            chk("pulse_kind", {29'd0, keyValid, parityError, frameError},
                it.kind == 0 ? 32'd4 : it.kind == 1 ? 32'd2 : 32'd1);
            chk("key_value", {24'd0, keyboardValue}, {24'd0, it.val});
            if (it.kind == 0) chk("key_ext", {31'd0, keyExtended}, {31'd0, it.ext});
         end
      end
   end

   task automatic chk_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_kv"}, {24'd0, keyboardValue}, 32'd0);
      chk({tag, "_valid"}, {31'd0, keyValid}, 32'd0);
      chk({tag, "_ext"}, {31'd0, keyExtended}, 32'd0);
      chk({tag, "_perr"}, {31'd0, parityError}, 32'd0);
      chk({tag, "_ferr"}, {31'd0, frameError}, 32'd0);
   endtask

   initial begin
      repeat (5) @(posedge clk);
      rst = 0;
      chk_reset_state("reset");
      repeat (10) @(posedge clk);
      expect_key(8'h1C, 1'b0);
      send(8'h1C, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      expect_key(8'h1D, 1'b0);
      send(8'h1D, 1'b0);
      send(8'hE0, 1'b0);
      expect_key(8'h75, 1'b1);
      send(8'h75, 1'b0);
      expect_key(8'h29, 1'b0);
      send(8'h29, 1'b0);
      expect_err(1);
      send(8'h29, 1'b1);
      expect_key(8'h16, 1'b0);
      send(8'h16, 1'b0);
      // E0 prefix before the aborted frame must not leak into the next key
      send(8'hE0, 1'b0);
      expect_err(2);
      send_bits(frame(8'h16, 1'b0), 5);
      repeat (TO + 100) @(posedge clk);
      expect_key(8'h16, 1'b0);
      send(8'h16, 1'b0);
      ps2_data = 0;
      @(posedge clk);
      ps2_clk = 0;
      repeat (2) @(posedge clk);
      ps2_clk = 1;
      repeat (20) @(posedge clk);
      ps2_data = 1;
      repeat (20) @(posedge clk);
      expect_key(8'h5A, 1'b0);
      send(8'h5A, 1'b0);
      send_bits(frame(8'h33, 1'b0), 6);
      rst = 1;
      repeat (3) @(posedge clk);
      chk_reset_state("midreset");
      rst = 0;
      exp_kv = 8'h00;
      repeat (10) @(posedge clk);
      expect_key(8'h45, 1'b0);
      send(8'h45, 1'b0);
      repeat (50) @(posedge clk);
      chk("pending_expected", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
